// File: rtl/ep_rr_sched.sv
// rtl/ep_rr_sched.sv - round-robin turn scheduler for a shared PCIe TRN transmit endpoint
// Offers the tx bus to one channel at a time and flags drive without a turn or overlong holds.
module ep_rr_sched #(
  parameter int NCHN     = 4,
  parameter int TURN_TMO = 3,
  parameter int HOLD_MAX = 1024
) (
  input  logic                    pcie_clk,
  input  logic                    pcie_rst,
  input  logic [NCHN-1:0]         chn_reqep,
  input  logic [NCHN-1:0]         chn_drvn,
  output logic [NCHN-1:0]         chn_trn,
  output logic [$clog2(NCHN)-1:0] owner,
  output logic                    busy,
  input  logic                    err_clr,
  output logic [NCHN-1:0]         err_unsol,
  output logic [NCHN-1:0]         err_hold
);

  localparam int OW = $clog2(NCHN);
  localparam int HW = $clog2(HOLD_MAX + 1);

  typedef enum logic [1:0] {ST_SELECT, ST_OFFER, ST_OWNED, ST_GAP} state_t;

  state_t          r_state, w_state_nxt;
  logic [OW-1:0]   r_last, r_owner, w_next, w_owner_nxt;
  logic [OW:0]     w_idx;
  logic [3:0]      r_ocnt;
  logic [HW-1:0]   r_hold;
  logic [NCHN-1:0] r_trn, w_trn_nxt, w_hold_set;
  logic [NCHN-1:0] r_err_unsol, r_err_hold;
  logic            r_busy, w_busy_nxt;
  logic            w_own_drv, w_tmo;

  assign w_own_drv = chn_drvn[r_owner];
  assign w_tmo     = (r_ocnt == 4'(TURN_TMO - 1));

  // Scan downward so the nearest requester after the last owner is the final write.
  always_comb begin
    w_next = (r_last == OW'(NCHN - 1)) ? '0 : r_last + OW'(1);
    w_idx  = '0;
    for (int k = NCHN; k >= 1; k--) begin
      w_idx = {1'b0, r_last} + (OW+1)'(k);
      if (w_idx >= (OW+1)'(NCHN)) w_idx = w_idx - (OW+1)'(NCHN);
      if (chn_reqep[w_idx[OW-1:0]]) w_next = w_idx[OW-1:0];
    end
  end

  always_ff @(posedge pcie_clk) begin
    if (pcie_rst) r_state <= ST_SELECT;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_SELECT: w_state_nxt = ST_OFFER;
      ST_OFFER: begin
        if (w_own_drv)  w_state_nxt = ST_OWNED;
        else if (w_tmo) w_state_nxt = ST_GAP;
      end
      ST_OWNED:  if (!w_own_drv) w_state_nxt = ST_GAP;
      ST_GAP:    w_state_nxt = ST_SELECT;
      default:   w_state_nxt = ST_SELECT;
    endcase
  end

  // Outputs are computed from the next state so chn_trn/busy/owner leave flops directly.
  always_comb begin
    w_owner_nxt = (r_state == ST_SELECT) ? w_next : r_owner;
    w_trn_nxt   = '0;
    if (w_state_nxt == ST_OFFER || w_state_nxt == ST_OWNED) w_trn_nxt[w_owner_nxt] = 1'b1;
    w_busy_nxt  = (w_state_nxt == ST_OWNED);
    w_hold_set  = '0;
    if (r_state == ST_OWNED && w_own_drv && r_hold == HW'(HOLD_MAX - 1)) w_hold_set[r_owner] = 1'b1;
  end

  always_ff @(posedge pcie_clk) begin
    if (pcie_rst) begin
      r_last      <= OW'(NCHN - 1);
      r_owner     <= '0;
      r_trn       <= '0;
      r_busy      <= 1'b0;
      r_ocnt      <= '0;
      r_hold      <= '0;
      r_err_unsol <= '0;
      r_err_hold  <= '0;
    end else begin
      if (r_state == ST_SELECT) r_last <= w_next;
      r_owner <= w_owner_nxt;
      r_trn   <= w_trn_nxt;
      r_busy  <= w_busy_nxt;
      r_ocnt  <= (r_state == ST_OFFER && w_state_nxt == ST_OFFER) ? r_ocnt + 4'd1 : 4'd0;
      if (r_state == ST_OWNED && w_state_nxt == ST_OWNED)
        r_hold <= (r_hold == HW'(HOLD_MAX)) ? r_hold : r_hold + HW'(1);
      else
        r_hold <= '0;
      // r_trn is exactly "holds the turn"; a new event beats a coincident clear.
      r_err_unsol <= (err_clr ? '0 : r_err_unsol) | (chn_drvn & ~r_trn);
      r_err_hold  <= (err_clr ? '0 : r_err_hold) | w_hold_set;
    end
  end

  assign chn_trn   = r_trn;
  assign owner     = r_owner;
  assign busy      = r_busy;
  assign err_unsol = r_err_unsol;
  assign err_hold  = r_err_hold;

endmodule

// File: tb/tb_ep_rr_sched.sv
// tb/tb_ep_rr_sched.sv - randomized turn-level checker for ep_rr_sched
// Each turn is scripted as select / offer / owned / gap cycles and compared every cycle.
module tb_ep_rr_sched;

  localparam int N  = 4;
  localparam int TT = 3;
  localparam int HM = 1024;

  logic                 pcie_clk = 1'b0;
  logic                 pcie_rst = 1'b1;
  logic                 err_clr  = 1'b0;
  logic [N-1:0]         chn_reqep = '0;
  logic [N-1:0]         chn_drvn  = '0;
  logic [N-1:0]         chn_trn, err_unsol, err_hold;
  logic [$clog2(N)-1:0] owner;
  logic                 busy;

  int           n_vec = 0;
  int           n_bad = 0;
  logic [N-1:0] m_unsol = '0;
  logic [N-1:0] m_hold  = '0;
  int           m_last  = N - 1;
  int           m_owner = 0;
  bit           g_intr  = 1'b0;

  ep_rr_sched #(.NCHN(N), .TURN_TMO(TT), .HOLD_MAX(HM)) dut (
    .pcie_clk (pcie_clk),
    .pcie_rst (pcie_rst),
    .chn_reqep(chn_reqep),
    .chn_drvn (chn_drvn),
    .chn_trn  (chn_trn),
    .owner    (owner),
    .busy     (busy),
    .err_clr  (err_clr),
    .err_unsol(err_unsol),
    .err_hold (err_hold)
  );

  always #5 pcie_clk = ~pcie_clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int nxt(input int last, input logic [N-1:0] req);
    for (int k = 1; k <= N; k++)
      if (req[(last + k) % N]) return (last + k) % N;
    return (last + 1) % N;
  endfunction

  // Called at a negedge: check this cycle's outputs, then drive this cycle's inputs.
  task automatic cyc(input logic [N-1:0] et, input logic eb, input int eo,
                     input logic [N-1:0] drv, input logic [N-1:0] req,
                     input logic rst, input logic [N-1:0] hset);
    logic [N-1:0] intr;
    logic         clr;
    chk("chn_trn",   32'(chn_trn),   32'(et));
    chk("busy",      32'(busy),      32'(eb));
    chk("owner",     32'(owner),     32'(eo));
    chk("err_unsol", 32'(err_unsol), 32'(m_unsol));
    chk("err_hold",  32'(err_hold),  32'(m_hold));
    intr = '0;
    if (g_intr && $urandom_range(0, 4) == 0) intr = N'(1 << $urandom_range(0, N - 1)) & ~et;
    clr = g_intr && ($urandom_range(0, 5) == 0);
    chn_drvn  = drv | intr;
    chn_reqep = req;
    err_clr   = clr;
    pcie_rst  = rst;
    m_unsol = (clr ? '0 : m_unsol) | ((drv | intr) & ~et);
    m_hold  = (clr ? '0 : m_hold) | hset;
    @(posedge pcie_clk);
    @(negedge pcie_clk);
    if (rst) begin
      m_unsol = '0;
      m_hold  = '0;
      m_last  = N - 1;
      m_owner = 0;
    end
  endtask

  // ds: offer cycle in which the owner takes (>= TT means never); len: total drive cycles;
  // rst_at: owned cycle in which reset is applied (-1 for none).
  task automatic do_turn(input logic [N-1:0] req, input int ds, input int len, input int rst_at);
    logic [N-1:0] oh;
    bit           took;
    bit           d;
    took = 1'b0;
    cyc('0, 1'b0, m_owner, '0, req, 1'b0, '0);
    m_owner = nxt(m_last, req);
    m_last  = m_owner;
    oh = N'(1) << m_owner;
    for (int o = 0; o < TT; o++) begin
      d = (o == ds);
      cyc(oh, 1'b0, m_owner, d ? oh : '0, N'($urandom), 1'b0, '0);
      if (d) begin
        took = 1'b1;
        break;
      end
    end
    if (took) begin
      for (int j = 0; j < HM + 100; j++) begin
        d = (j + 1 < len);
        if (j == rst_at) begin
          cyc(oh, 1'b1, m_owner, oh, N'($urandom), 1'b1, '0);
          return;
        end
        cyc(oh, 1'b1, m_owner, d ? oh : '0, N'($urandom), 1'b0, (d && j + 1 == HM) ? oh : '0);
        if (!d) break;
      end
    end
    cyc('0, 1'b0, m_owner, '0, N'($urandom), 1'b0, '0);
  endtask

  initial begin
    repeat (3) @(posedge pcie_clk);
    @(negedge pcie_clk);
    // Idle rotation through all channels and back to 0.
    for (int t = 0; t < 5; t++) do_turn('0, TT, 1, -1);
    do_turn(N'(4'b0100), TT, 1, -1);
    do_turn(N'(4'b0010), 1, 10, -1);
    do_turn('0, TT, 1, -1);
    g_intr = 1'b1;
    for (int t = 0; t < 80; t++)
      do_turn(($urandom_range(0, 1) == 0) ? '0 : N'($urandom), $urandom_range(0, TT),
              $urandom_range(1, 12), -1);
    do_turn('0, 0, HM + 5, -1);
    do_turn('0, 0, 8, 4);
    do_turn('0, TT, 1, -1);
    do_turn('0, 2, 3, -1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
